rr_grant_ctrl: RTL

Round-robin arbiter that shares the 3-to-8 one-hot select resource among eight requesters. It picks one requester per grant period, holds the grant while the requester keeps its request asserted, and pre-empts after a bounded hold time when others are waiting. Outputs are a registered 3-bit grant index, its one-hot decode and a valid flag, ready to drive the downstream select/enable lines directly.

---
 rtl/rr_grant_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/rr_grant_ctrl.sv
// Round-robin arbiter for eight requesters with bounded hold time.
// Grant index, one-hot decode, valid and new-grant pulse are all registered.
module rr_grant_ctrl #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic [7:0] req_i,
  output logic       gnt_valid_o,
  output logic [2:0] gnt_idx_o,
  output logic [7:0] gnt_onehot_o,
  output logic       gnt_new_o
);

  localparam int unsigned HW = $clog2(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    ptr_q, ptr_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    oh_q, oh_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          new_q, new_d;

  logic [7:0]    cand;
  logic          found;
  logic [2:0]    winner;
  logic          take_new;
  logic          go_idle;

  // oh_q is zero while idle, so masking it out only removes the current holder.
  always_comb begin
    cand   = req_i & ~oh_q;
    found  = |cand;
    winner = ptr_q;
    for (int i = 7; i >= 0; i--) begin
      if (cand[ptr_q + 3'(i)]) begin
        winner = ptr_q + 3'(i);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    oh_d     = oh_q;
    hold_d   = hold_q;
    new_d    = 1'b0;
    take_new = 1'b0;
    go_idle  = 1'b0;

    case (state_q)
      IDLE: begin
        if (en_i && found) begin
          take_new = 1'b1;
        end
      end
      GRANT: begin
        if (!en_i) begin
          go_idle = 1'b1;
        end else if (!req_i[idx_q]) begin
          if (found) begin
            take_new = 1'b1;
          end else begin
            go_idle = 1'b1;
          end
        end else if ((hold_q == HOLD_LAST) && found) begin
          take_new = 1'b1;
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: go_idle = 1'b1;
    endcase

    if (take_new) begin
      state_d = GRANT;
      idx_d   = winner;
      oh_d    = 8'b1 << winner;
      ptr_d   = winner + 3'd1;
      hold_d  = '0;
      new_d   = 1'b1;
    end else if (go_idle) begin
      state_d = IDLE;
      idx_d   = 3'd0;
      oh_d    = 8'h00;
      hold_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= 3'd0;
      idx_q   <= 3'd0;
      oh_q    <= 8'h00;
      hold_q  <= '0;
      new_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      oh_q    <= oh_d;
      hold_q  <= hold_d;
      new_q   <= new_d;
    end
  end

  assign gnt_valid_o  = (state_q == GRANT);
  assign gnt_idx_o    = idx_q;
  assign gnt_onehot_o = oh_q;
  assign gnt_new_o    = new_q;

endmodule
